// File: rtl/digital_clock_pkg.sv
// rtl/digital_clock_pkg.sv - shared encodings, limits and time helper for the digital clock
package digital_clock_pkg;

    typedef enum logic [1:0] {
        MODE_CLOCK     = 2'b00,
        MODE_SET_ALARM = 2'b01,
        MODE_STOPWATCH = 2'b10,
        MODE_SET_TIME  = 2'b11
    } mode_t;

    typedef enum logic [1:0] {
        FLD_HOUR = 2'd0,
        FLD_MIN  = 2'd1,
        FLD_EN   = 2'd2
    } field_t;

    localparam logic [4:0] MAX_HOUR = 5'd23;
    localparam logic [5:0] MAX_MIN  = 6'd59;

    typedef struct packed {
        logic [4:0] h;
        logic [5:0] m;
    } hm_t;

    // Adds up to 59 minutes to hh:mm, carrying into the hour and wrapping 23 -> 0.
    function automatic hm_t add_minutes(input logic [4:0] h, input logic [5:0] m,
                                        input logic [5:0] delta);
        hm_t        r;
        logic [6:0] sum;
        sum = {1'b0, m} + {1'b0, delta};
        r.h = h;
        r.m = sum[5:0];
        if (sum > {1'b0, MAX_MIN}) begin
            r.m = 6'(sum - 7'd60);
            r.h = (h == MAX_HOUR) ? 5'd0 : h + 5'd1;
        end
        return r;
    endfunction

endpackage

// File: rtl/hms_counter.sv
// rtl/hms_counter.sv - hh:mm:ss counter with clear, load and enable
module hms_counter
    import digital_clock_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       clr,
    input  logic       load,
    input  logic [4:0] load_h,
    input  logic [5:0] load_m,
    output logic [4:0] h,
    output logic [5:0] m,
    output logic [5:0] s
);

    // Clear beats load beats count; a load always restarts the seconds at zero.
    always_ff @(posedge clk) begin
        if (!rst || clr) begin
            h <= '0;
            m <= '0;
            s <= '0;
        end else if (load) begin
            h <= load_h;
            m <= load_m;
            s <= '0;
        end else if (en) begin
            if (s == MAX_MIN) begin
                s <= '0;
                if (m == MAX_MIN) begin
                    m <= '0;
                    h <= (h == MAX_HOUR) ? 5'd0 : h + 5'd1;
                end else begin
                    m <= m + 6'd1;
                end
            end else begin
                s <= s + 6'd1;
            end
        end
    end

endmodule

// File: rtl/digital_clock_multi.sv
// rtl/digital_clock_multi.sv - multi-alarm 12/24 h clock with snooze, timed ring and stopwatch
module digital_clock_multi
    import digital_clock_pkg::*;
#(
    parameter int  TICKS_PER_SEC = 1,
    parameter int  NUM_ALARMS    = 4,
    parameter int  SNOOZE_MIN    = 5,
    parameter int  RING_SEC      = 60,
    localparam int AW            = (NUM_ALARMS > 1) ? $clog2(NUM_ALARMS) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          twelve_24,
    input  logic [1:0]    mode_sel,
    input  logic [AW-1:0] alarm_idx,
    input  logic          toggle,
    input  logic          incr,
    input  logic          set_time,
    input  logic          set_alarm,
    input  logic          start_stop,
    input  logic          reset_sw_al,
    input  logic          snooze,
    input  logic          dismiss,
    output logic [4:0]    hours,
    output logic [5:0]    minutes,
    output logic [5:0]    seconds,
    output logic          am_pm,
    output logic          alarm_signal,
    output logic [AW-1:0] alarm_src
);

    localparam int PW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
    localparam int RW = $clog2(RING_SEC + 1);

    mode_t         mode;
    mode_t         mode_q;
    logic [AW-1:0] idx_q;
    logic [6:0]    btn_now;
    logic [6:0]    btn_q;
    logic [6:0]    btn_rise;

    logic          in_edit;
    logic          edit_load;
    logic          set_time_ev;
    logic          set_alarm_ev;
    logic          sw_toggle_ev;
    logic          sw_clr_ev;
    logic          snooze_ev;
    logic          dismiss_ev;

    logic [PW-1:0] presc;
    logic          tick;
    logic          tick_eff;
    logic          sec_wrap;

    logic [4:0]    time_h;
    logic [5:0]    time_m;
    logic [5:0]    time_s;
    logic [4:0]    sw_h;
    logic [5:0]    sw_m;
    logic [5:0]    sw_s;
    logic          sw_run;

    field_t        field_q;
    field_t        field_nxt;
    logic [4:0]    edit_h;
    logic [5:0]    edit_m;
    logic          edit_en;

    logic [4:0]    alarm_h [NUM_ALARMS];
    logic [5:0]    alarm_m [NUM_ALARMS];
    logic [NUM_ALARMS-1:0] alarm_en;

    hm_t           new_hm;
    logic          slot_hit;
    logic [AW-1:0] slot_sel;
    logic          snooze_hit;
    logic          snooze_pend;
    hm_t           snooze_tgt;
    logic [RW-1:0] ring_cnt;

    logic [4:0]    disp_h;

    assign mode    = mode_t'(mode_sel);
    assign btn_now = {dismiss, snooze, reset_sw_al, start_stop, set_alarm, set_time, toggle};
    assign btn_rise = btn_now & ~btn_q;

    assign in_edit      = (mode == MODE_SET_ALARM) || (mode == MODE_SET_TIME);
    assign edit_load    = (in_edit && (mode != mode_q)) ||
                          ((mode == MODE_SET_ALARM) && (alarm_idx != idx_q));
    assign set_time_ev  = btn_rise[1] && (mode == MODE_SET_TIME);
    assign set_alarm_ev = btn_rise[2] && (mode == MODE_SET_ALARM);
    assign sw_toggle_ev = btn_rise[3] && (mode == MODE_STOPWATCH);
    assign sw_clr_ev    = btn_rise[4] && (mode == MODE_STOPWATCH);
    assign snooze_ev    = btn_rise[5];
    assign dismiss_ev   = btn_rise[6];

    // Committing a new time swallows a coincident tick so the committed seconds stay at zero.
    assign tick     = (presc == PW'(TICKS_PER_SEC - 1));
    assign tick_eff = tick && !set_time_ev;
    assign sec_wrap = tick_eff && (time_s == MAX_MIN);
    assign new_hm   = add_minutes(time_h, time_m, 6'd1);

    // Previous-cycle copies of edge inputs, mode and slot index for edge and entry detection.
    always_ff @(posedge clk) begin
        if (!rst) begin
            btn_q  <= '0;
            mode_q <= MODE_CLOCK;
            idx_q  <= '0;
        end else begin
            btn_q  <= btn_now;
            mode_q <= mode;
            idx_q  <= alarm_idx;
        end
    end

    // Seconds prescaler; a time commit realigns it so a full second follows the commit.
    always_ff @(posedge clk) begin
        if (!rst || tick || set_time_ev) begin
            presc <= '0;
        end else begin
            presc <= presc + PW'(1);
        end
    end

    hms_counter u_time (
        .clk    (clk),
        .rst    (rst),
        .en     (tick_eff),
        .clr    (1'b0),
        .load   (set_time_ev),
        .load_h (edit_h),
        .load_m (edit_m),
        .h      (time_h),
        .m      (time_m),
        .s      (time_s)
    );

    hms_counter u_stopwatch (
        .clk    (clk),
        .rst    (rst),
        .en     (tick && sw_run),
        .clr    (sw_clr_ev),
        .load   (1'b0),
        .load_h (5'd0),
        .load_m (6'd0),
        .h      (sw_h),
        .m      (sw_m),
        .s      (sw_s)
    );

    // Stopwatch run flag: clearing also stops it.
    always_ff @(posedge clk) begin
        if (!rst || sw_clr_ev) begin
            sw_run <= 1'b0;
        end else if (sw_toggle_ev) begin
            sw_run <= ~sw_run;
        end
    end

    // Edit field register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            field_q <= FLD_HOUR;
        end else begin
            field_q <= field_nxt;
        end
    end

    // Edit field sequencing: the enable field only exists while editing an alarm.
    always_comb begin
        field_nxt = field_q;
        if (edit_load) begin
            field_nxt = FLD_HOUR;
        end else if (in_edit && btn_rise[0]) begin
            case (field_q)
                FLD_HOUR: field_nxt = FLD_MIN;
                FLD_MIN:  field_nxt = (mode == MODE_SET_ALARM) ? FLD_EN : FLD_HOUR;
                default:  field_nxt = FLD_HOUR;
            endcase
        end
    end

    // Edit buffer: reloaded on mode entry or slot change, otherwise stepped by incr.
    always_ff @(posedge clk) begin
        if (!rst) begin
            edit_h  <= '0;
            edit_m  <= '0;
            edit_en <= 1'b0;
        end else if (edit_load) begin
            if (mode == MODE_SET_ALARM) begin
                edit_h  <= alarm_h[alarm_idx];
                edit_m  <= alarm_m[alarm_idx];
                edit_en <= alarm_en[alarm_idx];
            end else begin
                edit_h  <= time_h;
                edit_m  <= time_m;
                edit_en <= 1'b0;
            end
        end else if (in_edit && incr) begin
            case (field_q)
                FLD_HOUR: edit_h  <= (edit_h == MAX_HOUR) ? 5'd0 : edit_h + 5'd1;
                FLD_MIN:  edit_m  <= (edit_m == MAX_MIN) ? 6'd0 : edit_m + 6'd1;
                FLD_EN:   edit_en <= ~edit_en;
                default:  ;
            endcase
        end
    end

    // Alarm slot storage, written only by an explicit commit.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < NUM_ALARMS; i++) begin
                alarm_h[i] <= '0;
                alarm_m[i] <= '0;
            end
            alarm_en <= '0;
        end else if (set_alarm_ev) begin
            alarm_h[alarm_idx]  <= edit_h;
            alarm_m[alarm_idx]  <= edit_m;
            alarm_en[alarm_idx] <= edit_en;
        end
    end

    // Slot matching against the time the clock is about to show; lowest index wins.
    always_comb begin
        slot_hit = 1'b0;
        slot_sel = '0;
        for (int i = NUM_ALARMS - 1; i >= 0; i--) begin
            if (alarm_en[i] && (alarm_h[i] == new_hm.h) && (alarm_m[i] == new_hm.m)) begin
                slot_hit = 1'b1;
                slot_sel = AW'(i);
            end
        end
    end

    assign snooze_hit = snooze_pend && (snooze_tgt == new_hm);

    // Ring control: a new match outranks dismiss and snooze arriving in the same cycle.
    always_ff @(posedge clk) begin
        if (!rst) begin
            alarm_signal <= 1'b0;
            alarm_src    <= '0;
            ring_cnt     <= '0;
            snooze_pend  <= 1'b0;
            snooze_tgt   <= '0;
        end else if (sec_wrap && (slot_hit || snooze_hit)) begin
            alarm_signal <= 1'b1;
            ring_cnt     <= RW'(RING_SEC);
            if (slot_hit) begin
                alarm_src <= slot_sel;
            end
            if (snooze_hit) begin
                snooze_pend <= 1'b0;
            end
        end else if (dismiss_ev) begin
            alarm_signal <= 1'b0;
            ring_cnt     <= '0;
            snooze_pend  <= 1'b0;
        end else if (snooze_ev && alarm_signal) begin
            alarm_signal <= 1'b0;
            ring_cnt     <= '0;
            snooze_pend  <= 1'b1;
            snooze_tgt   <= add_minutes(time_h, time_m, 6'(SNOOZE_MIN));
        end else if (tick_eff && alarm_signal) begin
            ring_cnt <= ring_cnt - RW'(1);
            if (ring_cnt == RW'(1)) begin
                alarm_signal <= 1'b0;
            end
        end
    end

    // Display mux with 12 h conversion; the stopwatch always shows raw hours.
    always_comb begin
        disp_h  = time_h;
        minutes = time_m;
        seconds = time_s;
        case (mode)
            MODE_SET_ALARM, MODE_SET_TIME: begin
                disp_h  = edit_h;
                minutes = edit_m;
                seconds = 6'd0;
            end
            MODE_STOPWATCH: begin
                disp_h  = sw_h;
                minutes = sw_m;
                seconds = sw_s;
            end
            default: ;
        endcase
        hours = disp_h;
        am_pm = 1'b0;
        if (twelve_24 && (mode != MODE_STOPWATCH)) begin
            if (disp_h == 5'd0) begin
                hours = 5'd12;
            end else if (disp_h == 5'd12) begin
                am_pm = 1'b1;
            end else if (disp_h > 5'd12) begin
                hours = disp_h - 5'd12;
                am_pm = 1'b1;
            end
        end
    end

endmodule

// File: doc/digital_clock_multi.md
# digital_clock_multi

Parametrised successor to the single-alarm digital clock. Keeps a 24 h time-of-day internally and shows it in 12 h or 24 h format. Adds a configurable seconds prescaler, NUM_ALARMS independently enabled alarms, a timed ring with auto-off, snooze/dismiss, and a stopwatch. Sits between the board clock and the display/buzzer drivers.

## Interface
- TICKS_PER_SEC, 1: clk cycles per second; must be ≥1.
- NUM_ALARMS, 4: alarm slots, ≥1. Localparam AW = max(1, $clog2(NUM_ALARMS)).
- SNOOZE_MIN, 5: snooze delay in minutes, 1..59.
- RING_SEC, 60: ring duration before auto-off, ≥1.
- clk in 1: single clock, rising edge.
- rst in 1: synchronous, active-low reset.
- twelve_24 in 1: 1 = 12 h display, 0 = 24 h display.
- mode_sel in 2: 00 clock, 01 set alarm, 10 stopwatch, 11 set time.
- alarm_idx in AW: alarm slot edited in mode 01.
- toggle in 1: edge; advances the edit field.
- incr in 1: level; increments the selected field once per clk while high.
- set_time in 1: edge; commits the edit buffer to time-of-day (mode 11 only).
- set_alarm in 1: edge; commits the edit buffer to alarm[alarm_idx] (mode 01 only).
- start_stop in 1: edge; toggles the stopwatch run state (mode 10 only).
- reset_sw_al in 1: edge; clears the stopwatch (mode 10 only).
- snooze in 1: edge; snoozes a ringing alarm.
- dismiss in 1: edge; silences the ring and cancels any pending snooze.
- hours out 5, minutes out 6, seconds out 6: displayed value.
- am_pm out 1: 1 = PM. Forced to 0 in 24 h mode and in mode 10.
- alarm_signal out 1: ring active.
- alarm_src out AW: slot that caused the current ring. For a snooze re-ring it keeps the original slot's value.

## Operation
- Reset state: time 00:00:00, prescaler 0. All alarms at 00:00 and disabled. Stopwatch at 0 and stopped. Snooze idle, ring off, edit field = HOUR. Outputs: hours 0 (12 in 12 h mode), minutes 0, seconds 0, am_pm 0, alarm_signal 0, alarm_src 0.
- Edge-sensitive inputs act on the first cycle they are sampled 1 after being sampled 0.
- Tick: the prescaler counts 0..TICKS_PER_SEC-1. The tick fires on the wrap.
- Per tick, time advances with carries: seconds 59→0, minutes 59→0, hours 23→0.
- The clock and the stopwatch advance in every mode.
- Edit buffer (edit_h, edit_m, edit_en):
  - Loaded when mode 01 or 11 is entered. Mode 01 loads from alarm[alarm_idx]; mode 11 loads from the current time.
  - Also reloaded when alarm_idx changes while in mode 01.
  - Field selection: toggle cycles HOUR→MIN→EN→HOUR in mode 01, and HOUR→MIN→HOUR in mode 11.
  - incr behaviour: HOUR wraps 23→0, MIN wraps 59→0, EN inverts.
  - Leaving the mode discards uncommitted edits.
- set_time sets time to edit_h:edit_m:00 and clears the prescaler. A tick in the same cycle is dropped.
- Alarm match:
  - Checked only on a tick whose new time has seconds = 0.
  - An enabled slot matches when hh:mm equals the new time. The lowest matching index wins.
  - A pending snooze target also matches. A slot match beats the snooze target.
  - A match sets alarm_signal and alarm_src and loads the ring counter to RING_SEC. A match while already ringing restarts the ring.
- Ring counter: decrements each tick. alarm_signal clears when it reaches 0.
- snooze while ringing: clears the ring and sets the snooze target to now + SNOOZE_MIN minutes, with hour wrap 23→0. snooze while not ringing is ignored.
- dismiss: clears the ring and the snooze target.
- Stopwatch: hh:mm:ss, counting on ticks while running. It wraps 23:59:59 → 0. reset_sw_al clears it and stops it.
- Display mux:
  - Mode 00: time.
  - Modes 01 and 11: edit_h:edit_m:00.
  - Mode 10: stopwatch.
- 12 h conversion of the hour value h: h = 0 shows 12 AM; h 1..11 show AM; h = 12 shows 12 PM; h 13..23 show h−12 PM.

## Timing
- All state is registered. An input edge produces its effect on the outputs one cycle later.
- hours, minutes, seconds and am_pm are combinational from registers, mode_sel and twelve_24. mode_sel and twelve_24 therefore affect the display within the same cycle.
- The alarm asserts in the cycle after the matching tick.
- Synchronous reset mid-operation wins over every other input in that cycle.

## Structure
- Package digital_clock_pkg holds:
  - the mode encodings (MODE_CLOCK, MODE_SET_ALARM, MODE_STOPWATCH, MODE_SET_TIME);
  - the field enum (FLD_HOUR, FLD_MIN, FLD_EN);
  - constants MAX_HOUR = 23 and MAX_MIN = 59.
- Sub-module hms_counter (en, clr, load, load_h, load_m → h, m, s) is instantiated twice: once for time-of-day and once for the stopwatch.

## Test plan
- TICKS_PER_SEC = 2, release reset, run 120 cycles → display shows 00:01:00. In 12 h mode hours = 12 and am_pm = 0.
- Mode 11: hold incr for 13 cycles (HOUR field), toggle, hold incr for 5 cycles (MIN field), then set_time → 13:05:00. twelve_24 = 1 gives 1 PM; twelve_24 = 0 gives 13, am_pm 0.
- Alarms:
  - Program slot 2 = 13:06, enabled, and slot 0 = 13:06, disabled.
  - Return to mode 00 → at 13:06:00 alarm_signal = 1 and alarm_src = 2.
  - With no further input, alarm_signal = 0 after RING_SEC seconds.
- Alarm at 23:58 with SNOOZE_MIN = 5: press snooze while ringing → re-ring at 00:03:00 with alarm_src unchanged. Repeat, then dismiss → no ring at 00:08:00.
- Stopwatch:
  - start_stop, wait 3 s → 00:00:03.
  - start_stop again, wait 2 s → still 00:00:03.
  - reset_sw_al → 00:00:00 and stopped.
  - The clock keeps advancing throughout.
- Boundaries:
  - set_time coincident with a tick → the committed value holds with seconds = 0.
  - Reset asserted while ringing → alarm_signal = 0 the next cycle and all slots disabled.
